alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Button-driven controller that sequences the 4-bit ALU for board operation: captures operand A, operand B, then operation/shift settings from shared switches, triggers one execution, and holds the registered 8-bit result for the BCD display path.
- Optional auto mode steps the operation select through all four codes at a fixed tick rate, so the displays cycle every result for the current operands.
- Sits between the board switches/pushbutton and the ALU/display block.

Parameters:
- TICK_DIV, 50000000, clock cycles per auto-mode step (1 s at 50 MHz); must be >= 2.
- CNT_W, 26, tick counter width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  asynchronous active-low reset
- sw_data  in  4  shared operand switches
- sw_op  in  2  operation select switches
- sw_shift1  in  1  shift switch 1
- sw_shift2  in  1  shift switch 2
- btn_next  in  1  raw pushbutton, active-high, asynchronous to clk
- auto_en  in  1  auto-cycle enable; level input, treated as quasi-static
- alu_result  in  8  ALU combinational result
- alu_num1  out  4  registered operand A to ALU
- alu_num2  out  4  registered operand B to ALU
- alu_op  out  2  registered operation select to ALU
- alu_shift1  out  1  registered shift control 1
- alu_shift2  out  1  registered shift control 2
- result_q  out  8  latched ALU result
- result_valid  out  1  result_q holds a result for the current settings
- state_code  out  3  current FSM state, for LEDs

Behaviour:
- Reset, asynchronous on rst_n low: all outputs 0, tick counter 0, synchroniser flops 0, state S_A (code 0). Reset mid-sequence discards captured values; no partial result survives.
- btn_next passes through a 2-flop synchroniser, then an edge detector: btn_pulse = sync2 & ~sync2_d. Raw high sampled at edge k produces btn_pulse during the cycle after edge k+1. The state and capture registers update at edge k+2. One pulse per press; holding the button does not repeat.
- States and codes: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_HOLD=4. Codes 5-7 are unreachable and recover to S_A on the next clock.
- S_A: on btn_pulse, alu_num1 <= sw_data, go to S_B.
- S_B: on btn_pulse, alu_num2 <= sw_data, go to S_OP.
- S_OP: on btn_pulse, alu_op <= sw_op, alu_shift1/2 <= sw_shift1/2, go to S_EXEC.
- S_EXEC: lasts exactly one cycle, unconditionally. result_q <= alu_result and result_valid <= 1, go to S_HOLD. The ALU is combinational and its inputs were registered one cycle earlier, so alu_result is settled.
- S_HOLD, auto_en=0: on btn_pulse, result_valid <= 0, go to S_A. result_q keeps its old value.
- S_HOLD, auto_en=1: btn_pulse is ignored.
  - Tick counter increments each cycle.
  - On the cycle where the counter equals TICK_DIV-1: counter <= 0, alu_op <= alu_op+1 (wraps 3 to 0), go to S_EXEC.
  - Resulting period between result_q updates: TICK_DIV+1 cycles.
- The tick counter is held at 0 whenever the state is not S_HOLD or auto_en=0.
- auto_en is ignored in S_A, S_B and S_OP. Deasserting it in S_HOLD freezes alu_op at its current value.
- btn_pulse arriving in S_EXEC is dropped.
- result_valid is 0 in S_A, S_B and S_OP after the first pass; result_q is never cleared except by reset.
- All outputs are registered; no combinational path from any input to any output.

Test Plan:
- Bench uses an ALU stub: alu_result = alu_num1*alu_num2 + alu_op, 8-bit.
- Reset: rst_n low with clk running, and once asynchronously mid-cycle -> all outputs 0, state_code=0 immediately, independent of clk.
- Manual sequence: press with sw_data=7, press with sw_data=9, press with sw_op=2 -> alu_num1=7, alu_num2=9, alu_op=2; one cycle later result_q=65, result_valid=1, state_code=4. Each press: state change exactly 2 clocks after the raw sample.
- Held and bouncing button: hold btn_next high 20 cycles in S_A -> exactly one advance to S_B. A single-cycle glitch produces at most one advance.
- Auto mode, TICK_DIV=4, A=3, B=5, op=0 in S_HOLD, auto_en=1:
  - result_q sequence 16, 17, 18, 15, 16, spaced 5 cycles apart.
  - alu_op wraps 3 to 0.
  - A button press in S_HOLD is ignored.
- Return path: auto_en=0 in S_HOLD, press -> result_valid=0, state_code=0, result_q unchanged. A press landing on the S_EXEC cycle is dropped.
- Reset mid-sequence: assert rst_n low in S_OP -> state S_A, alu_num1=0, result_valid=0. After release, the full sequence completes normally.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Board-side bundle for the ALU sequencer: shared switches, pushbutton,
// auto-mode enable, and the registered operand/result bus to the ALU and display.
//
// Signalling: there is no valid/ready handshake on this bus. btn_next is a raw
// asynchronous press (one sequencer step per rising edge). result_valid
// qualifies result_q: when it is 1, result_q belongs to the current
// alu_num1/alu_num2/alu_op/alu_shift settings. All sequencer outputs are registered.
interface alu_sequencer_if;
    logic [3:0] sw_data;
    logic [1:0] sw_op;
    logic       sw_shift1;
    logic       sw_shift2;
    logic       btn_next;
    logic       auto_en;
    logic [7:0] alu_result;
    logic [3:0] alu_num1;
    logic [3:0] alu_num2;
    logic [1:0] alu_op;
    logic       alu_shift1;
    logic       alu_shift2;
    logic [7:0] result_q;
    logic       result_valid;
    logic [2:0] state_code;

    // Sequencer side
    modport slave (
        input  sw_data, sw_op, sw_shift1, sw_shift2, btn_next, auto_en, alu_result,
        output alu_num1, alu_num2, alu_op, alu_shift1, alu_shift2,
               result_q, result_valid, state_code
    );

    // Board / ALU side
    modport master (
        output sw_data, sw_op, sw_shift1, sw_shift2, btn_next, auto_en, alu_result,
        input  alu_num1, alu_num2, alu_op, alu_shift1, alu_shift2,
               result_q, result_valid, state_code
    );
endinterface

// File: rtl/alu_sequencer.sv
// Button-driven sequencer for the 4-bit ALU: captures operand A, operand B and
// the op/shift settings on successive presses, runs one execution cycle, and
// holds the result. In auto mode it steps alu_op every TICK_DIV+1 cycles.
module alu_sequencer #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_sequencer_if.slave bus
);

    localparam logic [2:0] S_A    = 3'd0;
    localparam logic [2:0] S_B    = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_HOLD = 3'd4;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    logic             sync1_q, sync2_q, sync3_q;
    logic             btn_pulse;
    logic [2:0]       state_q, state_d;
    logic [3:0]       num1_q, num1_d;
    logic [3:0]       num2_q, num2_d;
    logic [1:0]       op_q, op_d;
    logic             sh1_q, sh1_d;
    logic             sh2_q, sh2_d;
    logic [7:0]       res_q, res_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Two-flop synchroniser for the raw button plus one delay flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= bus.btn_next;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // One-cycle pulse per press; a held button does not repeat
    assign btn_pulse = sync2_q & ~sync3_q;

    // Next-state and capture logic; the tick counter only runs in S_HOLD with auto_en
    always_comb begin
        state_d = state_q;
        num1_d  = num1_q;
        num2_d  = num2_q;
        op_d    = op_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        res_d   = res_q;
        valid_d = valid_q;
        cnt_d   = '0;
        case (state_q)
            S_A: begin
                if (btn_pulse) begin
                    num1_d  = bus.sw_data;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (btn_pulse) begin
                    num2_d  = bus.sw_data;
                    state_d = S_OP;
                end
            end
            S_OP: begin
                if (btn_pulse) begin
                    op_d    = bus.sw_op;
                    sh1_d   = bus.sw_shift1;
                    sh2_d   = bus.sw_shift2;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // ALU inputs were registered a cycle ago, so alu_result is settled
                res_d   = bus.alu_result;
                valid_d = 1'b1;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (bus.auto_en) begin
                    if (cnt_q == TICK_LAST) begin
                        op_d    = op_q + 2'd1;
                        state_d = S_EXEC;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (btn_pulse) begin
                    valid_d = 1'b0;
                    state_d = S_A;
                end
            end
            default: begin
                state_d = S_A;
            end
        endcase
    end

    // Sequencer state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
            num1_q  <= '0;
            num2_q  <= '0;
            op_q    <= '0;
            sh1_q   <= 1'b0;
            sh2_q   <= 1'b0;
            res_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            num1_q  <= num1_d;
            num2_q  <= num2_d;
            op_q    <= op_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.alu_num1     = num1_q;
    assign bus.alu_num2     = num2_q;
    assign bus.alu_op       = op_q;
    assign bus.alu_shift1   = sh1_q;
    assign bus.alu_shift2   = sh2_q;
    assign bus.result_q     = res_q;
    assign bus.result_valid = valid_q;
    assign bus.state_code   = state_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a multiply-add ALU stub,
// directed scenarios with literal expectations, then randomized stimulus
// checked every cycle against a behavioural model.
module tb_alu_sequencer;

    localparam int TD = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    alu_sequencer_if bus ();

    alu_sequencer #(.TICK_DIV(TD), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ALU stub: num1*num2 + op, 8-bit
    assign bus.alu_result = {4'b0, bus.alu_num1} * {4'b0, bus.alu_num2} + {6'b0, bus.alu_op};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // advance n rising edges, then settle 2 time units
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // one-cycle press with the given switch settings, then let it take effect
    task automatic press(input logic [3:0] d, input logic [1:0] o);
        bus.sw_data  = d;
        bus.sw_op    = o;
        bus.btn_next = 1'b1;
        tick(1);
        bus.btn_next = 1'b0;
        tick(3);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a press takes effect at edge n when the raw button
    // was sampled high at edge n-2 and low at edge n-3.
    // phase: 0=await A, 1=await B, 2=await op, 3=execute, 4=hold
    // ------------------------------------------------------------------
    logic [2:0] m_hist;
    int m_phase, m_a, m_b, m_op, m_s1, m_s2, m_res, m_valid, m_h;
    wire m_eff = m_hist[1] & ~m_hist[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hist <= '0; m_phase <= 0; m_a <= 0; m_b <= 0; m_op <= 0;
            m_s1 <= 0; m_s2 <= 0; m_res <= 0; m_valid <= 0; m_h <= 0;
        end else begin
            m_hist <= {m_hist[1:0], bus.btn_next};
            case (m_phase)
                0: if (m_eff) begin m_a <= int'(bus.sw_data); m_phase <= 1; end
                1: if (m_eff) begin m_b <= int'(bus.sw_data); m_phase <= 2; end
                2: if (m_eff) begin
                    m_op <= int'(bus.sw_op);
                    m_s1 <= int'(bus.sw_shift1);
                    m_s2 <= int'(bus.sw_shift2);
                    m_phase <= 3;
                end
                3: begin
                    m_res <= (m_a * m_b + m_op) % 256;
                    m_valid <= 1;
                    m_h <= 0;
                    m_phase <= 4;
                end
                default: begin
                    if (bus.auto_en) begin
                        if (m_h + 1 == TD) begin
                            m_h <= 0;
                            m_op <= (m_op + 1) % 4;
                            m_phase <= 3;
                        end else begin
                            m_h <= m_h + 1;
                        end
                    end else begin
                        m_h <= 0;
                        if (m_eff) begin m_valid <= 0; m_phase <= 0; end
                    end
                end
            endcase
        end
    end

    // every-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        chk("cyc_state",  int'(bus.state_code),   m_phase);
        chk("cyc_num1",   int'(bus.alu_num1),     m_a);
        chk("cyc_num2",   int'(bus.alu_num2),     m_b);
        chk("cyc_op",     int'(bus.alu_op),       m_op);
        chk("cyc_shift1", int'(bus.alu_shift1),   m_s1);
        chk("cyc_shift2", int'(bus.alu_shift2),   m_s2);
        chk("cyc_result", int'(bus.result_q),     m_res);
        chk("cyc_valid",  int'(bus.result_valid), m_valid);
    end

    // ------------------------------------------------------------------
    // Directed scenarios followed by randomized stimulus
    // ------------------------------------------------------------------
    int exp_vals[5] = '{16, 17, 18, 15, 16};
    int chg_val[$];
    int chg_cyc[$];
    int chg_op[$];

    initial begin
        int last;
        int found;
        int r_keep;
        n_checks = 0;
        n_err    = 0;
        rst_n = 1'b0;
        bus.sw_data = '0; bus.sw_op = '0; bus.sw_shift1 = 1'b0; bus.sw_shift2 = 1'b0;
        bus.btn_next = 1'b0; bus.auto_en = 1'b0;

        // reset with clock running
        tick(3);
        chk("rst_state",  int'(bus.state_code), 0);
        chk("rst_result", int'(bus.result_q), 0);
        chk("rst_valid",  int'(bus.result_valid), 0);
        chk("rst_num1",   int'(bus.alu_num1), 0);
        rst_n = 1'b1;
        tick(2);

        // manual sequence, with press latency check on the first press
        bus.sw_data = 4'd7;
        bus.btn_next = 1'b1;
        tick(1);                       // raw sampled high at edge k
        bus.btn_next = 1'b0;
        tick(1);                       // after edge k+1
        chk("lat_before", int'(bus.state_code), 0);
        tick(1);                       // after edge k+2
        chk("lat_after", int'(bus.state_code), 1);
        chk("cap_num1", int'(bus.alu_num1), 7);
        tick(2);
        press(4'd9, 2'd0);
        chk("cap_num2", int'(bus.alu_num2), 9);
        bus.sw_op = 2'd2;
        bus.btn_next = 1'b1;
        tick(1);
        bus.btn_next = 1'b0;
        tick(2);
        chk("exec_state", int'(bus.state_code), 3);
        chk("cap_op", int'(bus.alu_op), 2);
        tick(1);
        chk("man_result", int'(bus.result_q), 65);
        chk("man_valid",  int'(bus.result_valid), 1);
        chk("man_hold",   int'(bus.state_code), 4);

        // return path with auto off
        press(4'd0, 2'd0);
        chk("ret_state",  int'(bus.state_code), 0);
        chk("ret_valid",  int'(bus.result_valid), 0);
        chk("ret_result", int'(bus.result_q), 65);

        // held button: one advance only
        bus.sw_data = 4'd4;
        bus.btn_next = 1'b1;
        tick(20);
        bus.btn_next = 1'b0;
        tick(4);
        chk("held_state", int'(bus.state_code), 1);
        // single-cycle glitch: exactly one more advance
        bus.btn_next = 1'b1;
        tick(1);
        bus.btn_next = 1'b0;
        tick(4);
        chk("glitch_state", int'(bus.state_code), 2);

        // asynchronous reset mid-cycle while in S_OP
        rst_n = 1'b0;
        #1;
        chk("arst_state", int'(bus.state_code), 0);
        chk("arst_num1",  int'(bus.alu_num1), 0);
        chk("arst_valid", int'(bus.result_valid), 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        // full sequence A=3, B=5, op=0, then auto mode
        press(4'd3, 2'd0);
        press(4'd5, 2'd0);
        bus.auto_en = 1'b1;
        bus.sw_op = 2'd0;
        bus.btn_next = 1'b1;
        tick(1);
        bus.btn_next = 1'b0;
        tick(3);
        chk("auto_first", int'(bus.result_q), 15);
        last = int'(bus.result_q);
        for (int i = 0; i < 40; i++) begin
            if (i == 7) bus.btn_next = 1'b1;
            if (i == 8) bus.btn_next = 1'b0;
            tick(1);
            if (int'(bus.result_q) != last) begin
                last = int'(bus.result_q);
                chg_val.push_back(last);
                chg_cyc.push_back(i);
                chg_op.push_back(int'(bus.alu_op));
            end
        end
        if (chg_val.size() < 5) chk("auto_changes", chg_val.size(), 5);
        for (int i = 0; i < 5 && i < chg_val.size(); i++) begin
            chk("auto_value", chg_val[i], exp_vals[i]);
            if (i > 0) chk("auto_spacing", chg_cyc[i] - chg_cyc[i-1], TD + 1);
        end
        if (chg_op.size() >= 4) begin
            chk("auto_op3", chg_op[2], 3);
            chk("auto_wrap", chg_op[3], 0);
        end

        // press landing on the S_EXEC cycle is dropped
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick(1);
            if (bus.state_code == 3'd3) found = 1;
        end
        chk("exec_seen", found, 1);
        tick(3);
        bus.btn_next = 1'b1;
        tick(1);
        bus.btn_next = 1'b0;
        tick(1);
        chk("drop_exec", int'(bus.state_code), 3);
        bus.auto_en = 1'b0;
        tick(3);
        chk("drop_hold", int'(bus.state_code), 4);
        chk("drop_valid", int'(bus.result_valid), 1);

        // return from hold with auto off
        r_keep = int'(bus.result_q);
        press(4'd0, 2'd0);
        chk("ret2_state",  int'(bus.state_code), 0);
        chk("ret2_valid",  int'(bus.result_valid), 0);
        chk("ret2_result", int'(bus.result_q), r_keep);

        // randomized stimulus checked by the every-cycle compare
        repeat (250) begin
            bus.sw_data   = 4'($urandom_range(0, 15));
            bus.sw_op     = 2'($urandom_range(0, 3));
            bus.sw_shift1 = 1'($urandom_range(0, 1));
            bus.sw_shift2 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) bus.auto_en = ~bus.auto_en;
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
            bus.btn_next = 1'b1;
            tick($urandom_range(1, 3));
            bus.btn_next = 1'b0;
            tick($urandom_range(1, 6));
        end

        tick(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
